mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Sequences the single-port RAM between the instruction cache (fill reads) and the
//  data cache (fill reads / writebacks). Sits between both caches and the RAM.
//  Grants one requester at a time, holds the grant until RAM reports ACCESS, and
//  returns data/wait to the granted side.
// PARAMETERS
//  ADDR_W      32  width of iaddr/daddr/ramaddr
//  STARVE_MAX  4   consecutive D grants tolerated while iREN pends (fairness build only)
// PORTS
//  CLK       in   1       clock
//  nRST      in   1       reset, asynchronous, active-low
//  iREN      in   1       icache read request
//  iaddr     in   ADDR_W  icache request address
//  iwait     out  1       0 = iload valid this cycle
//  iload     out  32      RAM read data to icache
//  dREN      in   1       dcache read request
//  dWEN      in   1       dcache write request
//  daddr     in   ADDR_W  dcache request address
//  dstore    in   32      dcache write data
//  dwait     out  1       0 = dcache access completes this cycle
//  dload     out  32      RAM read data to dcache
//  ramREN    out  1       RAM read enable
//  ramWEN    out  1       RAM write enable
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  32      RAM write data
//  ramload   in   32      RAM read data
//  ramstate  in   2       ramstate_t: FREE/BUSY/ACCESS/ERROR
// BEHAVIOUR
//  - Reset: state IDLE, iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
//  - FSM states: IDLE, DGRANT, IGRANT (registered).
//  - IDLE: if (dREN|dWEN) -> DGRANT; else if iREN -> IGRANT; else stay. No RAM enables in IDLE.
//  - DGRANT: ramaddr=daddr; ramWEN=dWEN; ramREN=dREN&~dWEN (write wins); ramstore=dstore.
//  - IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0.
//  - Completion: in grant state with ramstate==ACCESS, granted wait=0 that same cycle
//    (combinational); next edge -> IDLE. Ungranted wait always 1.
//  - Latency: request seen in IDLE -> RAM enable next cycle; one IDLE turnaround
//    cycle between back-to-back grants.
//  - iload=dload=ramload (pass-through; valid only when the matching wait=0).
//  - Requester drops request while granted (no ACCESS yet): RAM enables drop
//    combinationally that cycle; next edge -> IDLE.
//  - Requests must hold addr/data stable until wait=0; arbiter does not latch them.
//  - ramstate BUSY/FREE while granted: hold state, waits stay 1.
//  - ramstate ERROR: hold state and enables, wait stays 1 (retry until ACCESS).
//  - Reset asserted mid-access: immediate return to reset values; no ACCESS propagated.
// CONFIGURATION
//  - MEM_ARB_FAIR_EN defined: starvation counter (width $clog2(STARVE_MAX+1)) increments
//    on each DGRANT completion while iREN=1; clears on IGRANT completion or when
//    iREN=0 in IDLE. In IDLE with count==STARVE_MAX and iREN=1, IGRANT beats dcache.
//  - Not defined: strict dcache priority; counter absent; dcache may starve icache.
// STRUCTURE
//  - cpu_types_pkg: reuse word_t, ramstate_t; add arb_state_t enum {IDLE,DGRANT,IGRANT}.
//  - One sub-module when MEM_ARB_FAIR_EN: arb_starve_ctr (count, clear, sat flag).
//  - FSM next-state and output decode are a single always_comb; state in always_ff.
// TESTING
//  - Reset: nRST=0 -> iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0.
//  - iREN=1, iaddr=0x0040, RAM ACCESS after 2 BUSY -> ramREN=1 addr 0x0040,
//    iwait=0 on ACCESS cycle, iload=ramload.
//  - iREN & dWEN same cycle, daddr=0x0100, dstore=0xDEADBEEF -> DGRANT first, ramWEN=1;
//    after ACCESS + 1 IDLE cycle IGRANT.
//  - dREN dropped after 1 BUSY cycle -> enables 0 same cycle, IDLE next, dwait stays 1.
//  - MEM_ARB_FAIR_EN, STARVE_MAX=4, iREN held, dREN continuous -> 4 D grants then 1 I grant.
//  - nRST pulsed during IGRANT BUSY -> outputs to reset values, iwait never 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types.
//   word_t      : 32-bit data word moved between caches and RAM
//   ramstate_t  : status reported by the RAM each cycle
//   arb_state_t : memory arbiter grant state
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DGRANT = 2'b01,
    IGRANT = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// arb_starve_ctr: counts consecutive dcache grants completed while the icache
// is left waiting. Only present in the MEM_ARB_FAIR_EN build.
// Ports:
//   CLK, nRST  clock, asynchronous active-low reset
//   inc_i      a dcache grant completed while iREN was pending
//   clr_i      icache served, or icache no longer requesting
//   sat_o      count has reached MAX: icache must be served next
`ifdef MEM_ARB_FAIR_EN
module arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !sat_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port RAM between icache fills and dcache
// fills/writebacks. One requester is granted at a time; the grant is held
// until the RAM reports ACCESS, then the FSM returns to IDLE for one
// turnaround cycle. Request address/data are passed through, not latched.
// Build option: MEM_ARB_FAIR_EN adds a starvation counter so the icache is
// served after STARVE_MAX consecutive dcache grants; otherwise the dcache
// has strict priority.
// Ports:
//   CLK, nRST                    clock, asynchronous active-low reset
//   iREN, iaddr / iwait, iload   icache request / response
//   dREN, dWEN, daddr, dstore    dcache request
//   dwait, dload                 dcache response
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate RAM interface
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output word_t             iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  word_t             dstore,
  output logic              dwait,
  output word_t             dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  ramstate_t         ramstate
);

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  arb_state_t state_q, state_d;
  logic       d_req;
  logic       i_first;  // icache overrides dcache priority in IDLE

  assign d_req = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

`ifdef MEM_ARB_FAIR_EN
  logic starve_inc, starve_clr, starve_sat;

  assign starve_inc = (state_q == DGRANT) && d_req && (ramstate == ACCESS) && iREN;
  assign starve_clr = ((state_q == IGRANT) && iREN && (ramstate == ACCESS)) ||
                      ((state_q == IDLE) && !iREN);
  assign i_first    = iREN && starve_sat;

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve_ctr (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .sat_o (starve_sat)
  );
`else
  assign i_first = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state and RAM/cache outputs. All outputs are decoded from the
  // registered state, so reset forces them straight to their idle values.
  always_comb begin
    state_d  = state_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if (i_first)
          state_d = IGRANT;
        else if (d_req)
          state_d = DGRANT;
        else if (iREN)
          state_d = IGRANT;
      end
      DGRANT: begin
        if (!d_req) begin
          // Request withdrawn before completion: release the RAM.
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;  // write wins if both asserted
          ramstore = dstore;
          // BUSY/FREE/ERROR all hold the grant; ERROR is retried.
          if (ramstate == ACCESS) begin
            dwait   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == ACCESS) begin
            iwait   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
